// File: rtl/pu_pkg.sv
// pu_pkg: shared types and helpers for the
// approximate-term accumulate unit.
package pu_pkg;

  localparam int XMAX = 32;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    OUT_HOLD
  } acc_state_t;

  function automatic int tree_depth(input int n_ch);
    return $clog2(n_ch);
  endfunction

  function automatic int sum_w(input int xlen, input int n_ch);
    return xlen + $clog2(n_ch);
  endfunction

  // {3'b100, op[xlen-2:2]}, built with shifts so
  // any xlen up to XMAX works
  function automatic logic [XMAX-1:0] approx_term(
    input logic [XMAX-1:0] op,
    input int              xlen
  );
    logic [XMAX-1:0] lo_mask;
    lo_mask = (XMAX'(1) << (xlen - 3)) - XMAX'(1);
    return ((op >> 2) & lo_mask)
         | (XMAX'(1) << (xlen - 1));
  endfunction

endpackage

// File: rtl/pu_accum_if.sv
// pu_accum_if: beat input and frame result
// valid/ready channels of pu_accum.
interface pu_accum_if #(
  parameter int XLEN  = 5,
  parameter int N_CH  = 4,
  parameter int ACC_W = 12
);
  logic [N_CH*XLEN-1:0] in_data;
  logic [N_CH-1:0]      in_mode;
  logic                 in_last;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_W-1:0]     out_data;
  logic                 out_ovf;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_mode, in_last, in_valid,
    output out_ready,
    input  in_ready, out_data, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_mode, in_last, in_valid,
    input  out_ready,
    output in_ready, out_data, out_ovf, out_valid
  );
endinterface

// File: rtl/pu_adder_tree.sv
// pu_adder_tree: pipelined pairwise sum of N_CH
// leaves; ports en (stall), leaf/valid/last in, sum out.
module pu_adder_tree
  import pu_pkg::*;
#(
  parameter  int XLEN = 5,
  parameter  int N_CH = 4,
  localparam int SW   = sum_w(XLEN, N_CH),
  localparam int DEP  = tree_depth(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_CH*XLEN-1:0] leaf,
  input  logic                 leaf_valid,
  input  logic                 leaf_last,
  output logic [SW-1:0]        sum,
  output logic                 sum_valid,
  output logic                 sum_last
);

  // heap layout: node i sums kids 2i and 2i+1,
  // kids N_CH.. are the leaves, kid 1 is the root
  logic [SW-1:0]  node [1:N_CH-1];
  logic [SW-1:0]  kid  [1:2*N_CH-1];
  logic [DEP-1:0] vp;
  logic [DEP-1:0] lp;

  always_comb begin
    for (int i = 1; i < N_CH; i++)
      kid[i] = node[i];
    for (int c = 0; c < N_CH; c++)
      kid[N_CH+c] = SW'(leaf[c*XLEN +: XLEN]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < N_CH; i++)
        node[i] <= '0;
      vp <= '0;
      lp <= '0;
    end else if (en) begin
      for (int i = 1; i < N_CH; i++)
        node[i] <= kid[2*i] + kid[2*i+1];
      vp[0] <= leaf_valid;
      lp[0] <= leaf_last;
      for (int i = 1; i < DEP; i++) begin
        vp[i] <= vp[i-1];
        lp[i] <= lp[i-1];
      end
    end
  end

  assign sum       = kid[1];
  assign sum_valid = vp[DEP-1];
  assign sum_last  = lp[DEP-1];

endmodule

// File: rtl/pu_accum.sv
// pu_accum: term stage, adder tree, frame accumulator;
// ports clk, rst (async, low), bus (pu_accum_if.slave).
module pu_accum
  import pu_pkg::*;
#(
  parameter int XLEN  = 5,
  parameter int N_CH  = 4,
  parameter int ACC_W = 12,
  parameter bit SAT   = 1'b1
) (
  input logic       clk,
  input logic       rst,
  pu_accum_if.slave bus
);

  localparam int SW = sum_w(XLEN, N_CH);

  logic                 adv;
  logic                 beat;
  logic [N_CH*XLEN-1:0] term_d;
  logic [N_CH*XLEN-1:0] term_q;
  logic                 t_valid;
  logic                 t_last;
  logic [SW-1:0]        s_sum;
  logic                 s_valid;
  logic                 s_last;
  acc_state_t           state;
  acc_state_t           state_d;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_d;
  logic                 ovf;
  logic                 ovf_d;
  logic [ACC_W-1:0]     res_q;
  logic [ACC_W-1:0]     res_d;
  logic                 rovf_q;
  logic                 rovf_d;
  logic [ACC_W:0]       tot;
  logic [ACC_W-1:0]     nxt;
  logic                 nxt_ovf;

  assign adv           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready  = adv;
  assign bus.out_valid = (state == OUT_HOLD);
  assign bus.out_data  = res_q;
  assign bus.out_ovf   = rovf_q;

  always_comb begin
    term_d = '0;
    for (int c = 0; c < N_CH; c++)
      term_d[c*XLEN +: XLEN] = bus.in_mode[c]
        ? XLEN'(approx_term(
            XMAX'(bus.in_data[c*XLEN +: XLEN]), XLEN))
        : bus.in_data[c*XLEN +: XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term_q  <= '0;
      t_valid <= 1'b0;
      t_last  <= 1'b0;
    end else if (adv) begin
      term_q  <= term_d;
      t_valid <= bus.in_valid;
      t_last  <= bus.in_last;
    end
  end

  pu_adder_tree #(
    .XLEN (XLEN),
    .N_CH (N_CH)
  ) u_tree (
    .clk        (clk),
    .rst        (rst),
    .en         (adv),
    .leaf       (term_q),
    .leaf_valid (t_valid),
    .leaf_last  (t_last),
    .sum        (s_sum),
    .sum_valid  (s_valid),
    .sum_last   (s_last)
  );

  // acc is zero outside ACC_RUN, so one adder
  // serves the first beat of a frame as well
  assign tot     = {1'b0, acc} + (ACC_W+1)'(s_sum);
  assign nxt     = (SAT && tot[ACC_W]) ? '1
                 : tot[ACC_W-1:0];
  assign nxt_ovf = ovf | tot[ACC_W];
  assign beat    = s_valid && adv;

  always_comb begin
    state_d = state;
    acc_d   = acc;
    ovf_d   = ovf;
    res_d   = res_q;
    rovf_d  = rovf_q;
    unique case (state)
      ACC_IDLE, ACC_RUN: state_d = state;
      OUT_HOLD: if (adv) state_d = ACC_IDLE;
      default:  state_d = ACC_IDLE;
    endcase
    // a beat landing on the output handshake
    // starts the next frame right away
    if (beat) begin
      if (s_last) begin
        res_d   = nxt;
        rovf_d  = nxt_ovf;
        acc_d   = '0;
        ovf_d   = 1'b0;
        state_d = OUT_HOLD;
      end else begin
        acc_d   = nxt;
        ovf_d   = nxt_ovf;
        state_d = ACC_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ACC_IDLE;
      acc    <= '0;
      ovf    <= 1'b0;
      res_q  <= '0;
      rovf_q <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      ovf    <= ovf_d;
      res_q  <= res_d;
      rovf_q <= rovf_d;
    end
  end

endmodule

// File: tb/tb_pu_accum.sv
// tb_pu_accum: directed vectors for pu_accum,
// default plus ACC_W=8 saturating/wrapping copies.
module tb_pu_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] in_data;
  logic [3:0]  in_mode;
  logic        in_last;
  logic        in_valid;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int n0;
  int cyc;
  logic [12:0] q[$];

  pu_accum_if #(.XLEN(5), .N_CH(4), .ACC_W(12)) a ();
  pu_accum_if #(.XLEN(5), .N_CH(4), .ACC_W(8))  s8 ();
  pu_accum_if #(.XLEN(5), .N_CH(4), .ACC_W(8))  w8 ();

  assign a.in_data    = in_data;
  assign a.in_mode    = in_mode;
  assign a.in_last    = in_last;
  assign a.in_valid   = in_valid;
  assign a.out_ready  = out_ready;
  assign s8.in_data   = in_data;
  assign s8.in_mode   = in_mode;
  assign s8.in_last   = in_last;
  assign s8.in_valid  = in_valid;
  assign s8.out_ready = out_ready;
  assign w8.in_data   = in_data;
  assign w8.in_mode   = in_mode;
  assign w8.in_last   = in_last;
  assign w8.in_valid  = in_valid;
  assign w8.out_ready = out_ready;

  pu_accum #(.XLEN(5), .N_CH(4), .ACC_W(12), .SAT(1'b1))
    dut (.clk(clk), .rst(rst), .bus(a.slave));
  pu_accum #(.XLEN(5), .N_CH(4), .ACC_W(8), .SAT(1'b1))
    dut_s8 (.clk(clk), .rst(rst), .bus(s8.slave));
  pu_accum #(.XLEN(5), .N_CH(4), .ACC_W(8), .SAT(1'b0))
    dut_w8 (.clk(clk), .rst(rst), .bus(w8.slave));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst && a.out_valid && a.out_ready) begin
      q.push_back({a.out_ovf, a.out_data});
      n_out++;
    end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ops(
    input int o0, input int o1,
    input int o2, input int o3
  );
    return {5'(o3), 5'(o2), 5'(o1), 5'(o0)};
  endfunction

  task automatic send(
    input logic [19:0] d,
    input logic [3:0]  m,
    input logic        l
  );
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    while (!a.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(n < 50), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!a.out_valid && c < 20);
  endtask

  initial begin
    int exp_q [3];
    exp_q = '{10, 40, 32};
    in_data   = '0;
    in_mode   = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // reset held with random inputs
    repeat (6) begin
      @(negedge clk);
      in_data   = 20'($urandom);
      in_mode   = 4'($urandom);
      in_last   = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
    end
    @(posedge clk);
    #1;
    check("rst_valid", a.out_valid, 0);
    check("rst_data", a.out_data, 0);
    check("rst_ovf", a.out_ovf, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("rst_in_ready", a.in_ready, 1);

    // exact single beat, latency
    send(ops(3, 5, 7, 9), 4'b0000, 1'b1);
    wait_out(cyc);
    check("exact_lat", cyc, 3);
    check("exact_data", a.out_data, 24);
    check("exact_ovf", a.out_ovf, 0);

    // approximate terms
    send(ops(31, 31, 31, 31), 4'b1110, 1'b1);
    wait_out(cyc);
    check("apx_valid", a.out_valid, 1);
    check("apx_data", a.out_data, 88);
    send(ops(8, 12, 0, 1), 4'b0011, 1'b1);
    wait_out(cyc);
    check("apx2_valid", a.out_valid, 1);
    check("apx2_data", a.out_data, 38);

    // three-beat frame, sat and wrap copies
    send(ops(31, 31, 31, 31), 4'b0000, 1'b0);
    n0 = n_out;
    send(ops(31, 31, 31, 31), 4'b0000, 1'b0);
    send(ops(31, 31, 31, 31), 4'b0000, 1'b1);
    wait_out(cyc);
    check("f3_valid", a.out_valid, 1);
    check("f3_data", a.out_data, 372);
    check("f3_ovf", a.out_ovf, 0);
    check("sat_data", s8.out_data, 255);
    check("sat_ovf", s8.out_ovf, 1);
    check("wrap_data", w8.out_data, 116);
    check("wrap_ovf", w8.out_ovf, 1);
    repeat (3) @(posedge clk);
    #1;
    check("f3_count", n_out - n0, 1);

    // idle gaps inside a frame
    send(ops(1, 1, 1, 1), 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    send(ops(2, 2, 2, 2), 4'b0000, 1'b1);
    wait_out(cyc);
    check("gap_valid", a.out_valid, 1);
    check("gap_data", a.out_data, 12);

    // backpressure on back-to-back frames
    @(posedge clk);
    #1;
    q.delete();
    out_ready = 1'b0;
    send(ops(1, 2, 3, 4), 4'b0000, 1'b1);
    send(ops(10, 10, 10, 10), 4'b0000, 1'b1);
    send(ops(31, 0, 0, 1), 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", a.out_valid, 1);
      check("bp_in_ready", a.in_ready, 0);
      check("bp_data", a.out_data, 10);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() < 3; i++)
      @(posedge clk);
    #1;
    check("bp_count", q.size(), 3);
    for (int i = 0; i < 3; i++)
      check("bp_order",
            q.size() > i ? 32'(q[i]) : '1,
            exp_q[i]);

    // reset in the middle of a frame
    send(ops(31, 31, 31, 31), 4'b0000, 1'b0);
    send(ops(31, 31, 31, 31), 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", a.out_valid, 0);
    check("mid_rst_data", a.out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    send(ops(1, 1, 1, 1), 4'b0000, 1'b1);
    wait_out(cyc);
    check("post_rst_valid", a.out_valid, 1);
    check("post_rst_data", a.out_data, 4);
    check("post_rst_ovf", a.out_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
